// File: rtl/urng_taus_pair_if.sv
// Bundle of seed-load handshake and output stream signals for urng_taus_pair.
//
// Signals (direction as seen by the generator block):
//   en_i          in   1   advance both generators while running
//   seedData_i    in   32  seed word
//   seedValid_i   in   1   seedData_i holds a word to transfer
//   seedReady_o   out  1   block accepts a seed word this cycle
//   a_o           out  32  generator A output word
//   b_o           out  32  generator B output word
//   oValid_o      out  1   a_o/b_o hold a fresh word this cycle
//   seeded_o      out  1   generators hold a seeded state and are running
//   sampleCnt_o   out  32  number of valid output pairs since the last reseed
//
// Modports: master drives seeds and enable, slave is the generator block.

interface urng_taus_pair_if;

   logic        en_i;
   logic [31:0] seedData_i;
   logic        seedValid_i;
   logic        seedReady_o;
   logic [31:0] a_o;
   logic [31:0] b_o;
   logic        oValid_o;
   logic        seeded_o;
   logic [31:0] sampleCnt_o;

   modport master (
      output en_i, seedData_i, seedValid_i,
      input  seedReady_o, a_o, b_o, oValid_o, seeded_o, sampleCnt_o
   );

   modport slave (
      input  en_i, seedData_i, seedValid_i,
      output seedReady_o, a_o, b_o, oValid_o, seeded_o, sampleCnt_o
   );

endinterface

// File: rtl/urng_taus_pair.sv
// Pair of independent taus88 (three-component combined Tausworthe) uniform
// generators, A and B, stepped in lockstep. Each enabled cycle in RUN yields
// one fresh 32-bit word per generator, intended to feed the a/b inputs of
// the Box-Muller AWGN core.
//
// Ports:
//   clk   in  1   rising-edge clock
//   rst   in  1   asynchronous, active-high reset
//   bus   urng_taus_pair_if.slave
//         en_i, seedData_i, seedValid_i in; seedReady_o, a_o, b_o,
//         oValid_o, seeded_o, sampleCnt_o out
//
// Parameters:
//   WARMUP_CYCLES  state advances discarded after seeding (0 = go straight to RUN)
//   DEF_S0/1/2     substitutes for component seeds below 2 / 8 / 16
//
// Optional feature macro: URNG_SAMPLE_CNT_EN
//   defined   -> sampleCnt_o counts valid output pairs, wraps, clears on reseed
//   undefined -> counter not built, sampleCnt_o tied to zero

module urng_taus_pair #(
   parameter int unsigned WARMUP_CYCLES = 16,
   parameter logic [31:0] DEF_S0        = 32'h0000_3039,
   parameter logic [31:0] DEF_S1        = 32'h0001_E240,
   parameter logic [31:0] DEF_S2        = 32'h0012_D687
) (
   input logic              clk,
   input logic              rst,
   urng_taus_pair_if.slave  bus
);

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      LOAD     = 2'd1,
      WARMUP   = 2'd2,
      RUN      = 2'd3
   } state_t;

   state_t      state_q;
   logic [2:0]  loadIdx_q;
   logic [31:0] warmCnt_q;
   logic [31:0] comp_q [6];
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        oValid_q;
   logic        seeded_q;

   logic [31:0] nextComp [6];
   logic [31:0] nextA;
   logic [31:0] nextB;
   logic        seedReady;
   logic        xfer;
   logic        loadEntry;
   logic        runAdvance;
   logic [2:0]  storeIdx;
   logic [31:0] legalWord;

   // The three Tausworthe component recurrences. Shifts are logical and
   // anything pushed past bit 31 is simply dropped.
   function automatic logic [31:0] stepS0(input logic [31:0] s);
      logic [31:0] t;
      t = ((s << 13) ^ s) >> 19;
      return ((s & 32'hFFFF_FFFE) << 12) ^ t;
   endfunction

   function automatic logic [31:0] stepS1(input logic [31:0] s);
      logic [31:0] t;
      t = ((s << 2) ^ s) >> 25;
      return ((s & 32'hFFFF_FFF8) << 4) ^ t;
   endfunction

   function automatic logic [31:0] stepS2(input logic [31:0] s);
      logic [31:0] t;
      t = ((s << 3) ^ s) >> 11;
      return ((s & 32'hFFFF_FFF0) << 17) ^ t;
   endfunction

   // Next state of both generators, always computed so that an advance is
   // just a register load. Slots 0..2 belong to A, 3..5 to B; the output
   // word is taken from the updated state so a/b are fresh on the same edge.
   always_comb begin
      nextComp[0] = stepS0(comp_q[0]);
      nextComp[1] = stepS1(comp_q[1]);
      nextComp[2] = stepS2(comp_q[2]);
      nextComp[3] = stepS0(comp_q[3]);
      nextComp[4] = stepS1(comp_q[4]);
      nextComp[5] = stepS2(comp_q[5]);
      nextA       = nextComp[0] ^ nextComp[1] ^ nextComp[2];
      nextB       = nextComp[3] ^ nextComp[4] ^ nextComp[5];
   end

   // Handshake decode. Seeds are refused only while warming up. A transfer
   // outside LOAD always starts a fresh load at slot 0, which is also what
   // lets a running block be reseeded. A RUN cycle with a transfer is spent
   // on the reseed rather than producing a word.
   always_comb begin
      seedReady  = (state_q != WARMUP);
      xfer       = bus.seedValid_i && seedReady;
      loadEntry  = xfer && ((state_q == UNSEEDED) || (state_q == RUN));
      runAdvance = (state_q == RUN) && !xfer && bus.en_i;
      storeIdx   = (state_q == LOAD) ? loadIdx_q : 3'd0;
   end

   // A component seed below its minimum would let that component collapse
   // into the all-zero lock-up state, so such words are swapped for the
   // default seed of the slot they are landing in.
   always_comb begin
      legalWord = bus.seedData_i;
      case (storeIdx)
         3'd0, 3'd3: if (bus.seedData_i < 32'd2)  legalWord = DEF_S0;
         3'd1, 3'd4: if (bus.seedData_i < 32'd8)  legalWord = DEF_S1;
         3'd2, 3'd5: if (bus.seedData_i < 32'd16) legalWord = DEF_S2;
         default:    legalWord = bus.seedData_i;
      endcase
   end

   // Control FSM together with the generator state and the registered
   // outputs. LOAD tolerates gaps in seedValid, simply holding its slot
   // index. WARMUP advances every cycle without regard to en and throws the
   // words away. In RUN, a/b and oValid are loaded on the same edge as the
   // state advance; a/b are left alone otherwise so they hold across en=0
   // cycles and across a reseed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= UNSEEDED;
         loadIdx_q <= 3'd0;
         warmCnt_q <= 32'd0;
         for (int i = 0; i < 6; i++) begin
            comp_q[i] <= 32'd0;
         end
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         oValid_q  <= 1'b0;
         seeded_q  <= 1'b0;
      end else begin
         oValid_q <= 1'b0;
         if (loadEntry) begin
            comp_q[0] <= legalWord;
            loadIdx_q <= 3'd1;
            state_q   <= LOAD;
            seeded_q  <= 1'b0;
         end else begin
            case (state_q)
               LOAD: begin
                  if (xfer) begin
                     comp_q[storeIdx] <= legalWord;
                     if (loadIdx_q == 3'd5) begin
                        loadIdx_q <= 3'd0;
                        if (WARMUP_CYCLES == 0) begin
                           state_q  <= RUN;
                           seeded_q <= 1'b1;
                        end else begin
                           state_q   <= WARMUP;
                           warmCnt_q <= 32'(WARMUP_CYCLES);
                        end
                     end else begin
                        loadIdx_q <= loadIdx_q + 3'd1;
                     end
                  end
               end
               WARMUP: begin
                  for (int i = 0; i < 6; i++) begin
                     comp_q[i] <= nextComp[i];
                  end
                  if (warmCnt_q <= 32'd1) begin
                     warmCnt_q <= 32'd0;
                     state_q   <= RUN;
                     seeded_q  <= 1'b1;
                  end else begin
                     warmCnt_q <= warmCnt_q - 32'd1;
                  end
               end
               RUN: begin
                  if (runAdvance) begin
                     for (int i = 0; i < 6; i++) begin
                        comp_q[i] <= nextComp[i];
                     end
                     a_q      <= nextA;
                     b_q      <= nextB;
                     oValid_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign bus.seedReady_o = seedReady;
   assign bus.a_o         = a_q;
   assign bus.b_o         = b_q;
   assign bus.oValid_o    = oValid_q;
   assign bus.seeded_o    = seeded_q;

`ifdef URNG_SAMPLE_CNT_EN
   logic [31:0] sampleCnt_q;

   // Valid-pair counter. It steps on exactly the edges that raise oValid,
   // so after each such edge it equals the number of pairs delivered since
   // the last load began. Wrap-around at the top is intentional.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sampleCnt_q <= 32'd0;
      end else if (loadEntry) begin
         sampleCnt_q <= 32'd0;
      end else if (runAdvance) begin
         sampleCnt_q <= sampleCnt_q + 32'd1;
      end
   end

   assign bus.sampleCnt_o = sampleCnt_q;
`else
   assign bus.sampleCnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_urng_taus_pair.sv
// Self-checking bench for urng_taus_pair. Two instances share one stimulus
// stream: dutW warms up for 16 advances, dutZ skips warm-up. A taus88
// reference model per instance predicts the handshake, the output stream
// and the held values; expected pairs are queued on issue and popped by a
// negedge monitor whenever an instance presents oValid.

module tb_urng_taus_pair;

   localparam int PH_UNSEEDED = 0;
   localparam int PH_LOAD     = 1;
   localparam int PH_WARM     = 2;
   localparam int PH_RUN      = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   urng_taus_pair_if busW ();
   urng_taus_pair_if busZ ();

   urng_taus_pair #(.WARMUP_CYCLES(16)) dutW (
      .clk (clk),
      .rst (rst),
      .bus (busW.slave)
   );

   urng_taus_pair #(.WARMUP_CYCLES(0)) dutZ (
      .clk (clk),
      .rst (rst),
      .bus (busZ.slave)
   );

   int          tests  = 0;
   int          errors = 0;
   int          warmCfg [2] = '{16, 0};
   logic [31:0] mS [2][6];
   int          mPhase [2];
   int          mIdx [2];
   int          mWarm [2];
   logic [31:0] mHoldA [2];
   logic [31:0] mHoldB [2];
   logic [31:0] mCnt [2];
   logic        mValid [2];
   int          zeroRun [2];
   logic [63:0] expQ0 [$];
   logic [63:0] expQ1 [$];
   logic [31:0] seedBuf [6];
   bit          monOn = 1'b0;

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
      end
   endtask

   function automatic logic [31:0] legalSeed(input int slot, input logic [31:0] w);
      case (slot % 3)
         0:       return (w < 32'd2)  ? 32'h0000_3039 : w;
         1:       return (w < 32'd8)  ? 32'h0001_E240 : w;
         default: return (w < 32'd16) ? 32'h0012_D687 : w;
      endcase
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) mS[k][i] = 32'd0;
         mPhase[k]  = PH_UNSEEDED;
         mIdx[k]    = 0;
         mWarm[k]   = 0;
         mHoldA[k]  = 32'd0;
         mHoldB[k]  = 32'd0;
         mCnt[k]    = 32'd0;
         mValid[k]  = 1'b0;
         zeroRun[k] = 0;
      end
      expQ0.delete();
      expQ1.delete();
   endtask

   // Classic taus88 update, one generator at a time.
   task automatic modelAdvance(input int k);
      logic [31:0] s1, s2, s3, t;
      for (int g = 0; g < 2; g++) begin
         s1 = mS[k][3*g];
         s2 = mS[k][3*g+1];
         s3 = mS[k][3*g+2];
         t  = ((s1 << 13) ^ s1) >> 19;
         s1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ t;
         t  = ((s2 << 2) ^ s2) >> 25;
         s2 = ((s2 & 32'hFFFF_FFF8) << 4) ^ t;
         t  = ((s3 << 3) ^ s3) >> 11;
         s3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ t;
         mS[k][3*g]   = s1;
         mS[k][3*g+1] = s2;
         mS[k][3*g+2] = s3;
      end
   endtask

   task automatic modelStep(input int k, input bit sv, input logic [31:0] sd, input bit en);
      bit xfer;
      logic [31:0] wa, wb;
      mValid[k] = 1'b0;
      xfer = sv && (mPhase[k] != PH_WARM);
      if (xfer && (mPhase[k] == PH_UNSEEDED || mPhase[k] == PH_RUN)) begin
         mS[k][0]  = legalSeed(0, sd);
         mIdx[k]   = 1;
         mPhase[k] = PH_LOAD;
         mCnt[k]   = 32'd0;
      end else if (xfer && mPhase[k] == PH_LOAD) begin
         mS[k][mIdx[k]] = legalSeed(mIdx[k], sd);
         if (mIdx[k] == 5) begin
            if (warmCfg[k] == 0) begin
               mPhase[k] = PH_RUN;
            end else begin
               mPhase[k] = PH_WARM;
               mWarm[k]  = warmCfg[k];
            end
         end else begin
            mIdx[k]++;
         end
      end else if (mPhase[k] == PH_WARM) begin
         modelAdvance(k);
         mWarm[k]--;
         if (mWarm[k] == 0) mPhase[k] = PH_RUN;
      end else if (mPhase[k] == PH_RUN && en) begin
         modelAdvance(k);
         wa = mS[k][0] ^ mS[k][1] ^ mS[k][2];
         wb = mS[k][3] ^ mS[k][4] ^ mS[k][5];
         mHoldA[k] = wa;
         mHoldB[k] = wb;
         mValid[k] = 1'b1;
         mCnt[k]   = mCnt[k] + 32'd1;
         if (k == 0) expQ0.push_back({wa, wb});
         else        expQ1.push_back({wa, wb});
      end
   endtask

   // One clock of stimulus: drive both instances, let the edge happen,
   // then bring the reference model up to the same edge.
   task automatic applyStimulus(input bit sv, input logic [31:0] sd, input bit en);
      busW.seedValid_i = sv;
      busW.seedData_i  = sd;
      busW.en_i        = en;
      busZ.seedValid_i = sv;
      busZ.seedData_i  = sd;
      busZ.en_i        = en;
      @(posedge clk);
      modelStep(0, sv, sd, en);
      modelStep(1, sv, sd, en);
      #1;
   endtask

   task automatic loadSeeds();
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 2)) applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)));
         applyStimulus(1'b1, seedBuf[i], 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic runCycles(input int n, input int pctEn);
      repeat (n) applyStimulus(1'b0, $urandom, ($urandom_range(0, 99) < pctEn));
   endtask

   task automatic checkOutput(input int k, input logic ready, input logic seeded,
                              input logic ov, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] cnt);
      logic [63:0] e;
      check("seed_ready", k, 32'(ready), 32'(mPhase[k] != PH_WARM));
      check("seeded", k, 32'(seeded), 32'(mPhase[k] == PH_RUN));
      check("ovalid", k, 32'(ov), 32'(mValid[k]));
      if (ov) begin
         if ((k == 0 && expQ0.size() == 0) || (k == 1 && expQ1.size() == 0)) begin
            tests++;
            errors++;
            $display("[TB] FAIL unexpected_word dut%0d: got a=%h b=%h, expected no word", k, a, b);
         end else begin
            e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
            check("a_word", k, a, e[63:32]);
            check("b_word", k, b, e[31:0]);
         end
         zeroRun[k] = (a == 32'd0) ? zeroRun[k] + 1 : 0;
         check("a_zero_run", k, 32'(zeroRun[k] >= 4), 32'd0);
      end else begin
         check("a_hold", k, a, mHoldA[k]);
         check("b_hold", k, b, mHoldB[k]);
      end
`ifdef URNG_SAMPLE_CNT_EN
      check("sample_cnt", k, cnt, mCnt[k]);
`else
      check("sample_cnt", k, cnt, 32'd0);
`endif
   endtask

   // Monitor: independent of the stimulus process, looks at both
   // instances half a cycle after each active edge.
   always @(negedge clk) begin
      if (monOn && !rst) begin
         checkOutput(0, busW.seedReady_o, busW.seeded_o, busW.oValid_o,
                     busW.a_o, busW.b_o, busW.sampleCnt_o);
         checkOutput(1, busZ.seedReady_o, busZ.seeded_o, busZ.oValid_o,
                     busZ.a_o, busZ.b_o, busZ.sampleCnt_o);
      end
   end

   task automatic checkReset();
      check("rst_a", 0, busW.a_o, 32'd0);
      check("rst_b", 0, busW.b_o, 32'd0);
      check("rst_ovalid", 0, 32'(busW.oValid_o), 32'd0);
      check("rst_seeded", 0, 32'(busW.seeded_o), 32'd0);
      check("rst_seed_ready", 0, 32'(busW.seedReady_o), 32'd1);
      check("rst_sample_cnt", 0, busW.sampleCnt_o, 32'd0);
      check("rst_a", 1, busZ.a_o, 32'd0);
      check("rst_b", 1, busZ.b_o, 32'd0);
      check("rst_ovalid", 1, 32'(busZ.oValid_o), 32'd0);
      check("rst_seeded", 1, 32'(busZ.seeded_o), 32'd0);
      check("rst_seed_ready", 1, 32'(busZ.seedReady_o), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      busW.seedValid_i = 1'b0; busW.seedData_i = 32'd0; busW.en_i = 1'b0;
      busZ.seedValid_i = 1'b0; busZ.seedData_i = 32'd0; busZ.en_i = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #2;
      checkReset();
      @(posedge clk);
      #1;
      rst   = 1'b0;
      monOn = 1'b1;

      // Reference seeds, then an en pattern 1,0,0,1 once both are running.
      seedBuf = '{32'd12345, 32'd12345, 32'd12345, 32'd67890, 32'd67890, 32'd67890};
      loadSeeds();
      runCycles(40, 100);
      applyStimulus(1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      runCycles(150, 70);

      // Reseed in RUN with seeds that all need substitution.
      seedBuf = '{32'd1, 32'd7, 32'd15, 32'd0, 32'd3, 32'd9};
      loadSeeds();
      runCycles(120, 80);

      // Random reseeds, small values mixed in to hit the substitution edges.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 6; i++)
            seedBuf[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         loadSeeds();
         runCycles(100, 75);
      end

      // Asynchronous reset in the middle of a running stream with en=1.
      applyStimulus(1'b0, 32'd0, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkReset();
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      seedBuf = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      loadSeeds();
      runCycles(60, 90);

      @(negedge clk);
      #1;
      check("queue_drain", 0, 32'(expQ0.size()), 32'd0);
      check("queue_drain", 1, 32'(expQ1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
